sparse_frame_buffer: RTL

- Parametrised buffer between the UART comm block and the FPU/TX path of the sparse-matrix coprocessor.
- Generalises the single-entry frame memory into a DEPTH-entry circular FIFO of DATA_W-bit frames.
- Writes are driven by the comm block's rx_complete; reads are triggered internally by the falling edge of fpu_complete.
- Adds occupancy, full/empty, sticky overflow/underflow status and a synchronous flush.

---
 rtl/sparse_cop_pkg.sv | 14 +
 rtl/sparse_fall_edge.sv | 22 ++
 rtl/sparse_frame_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/sparse_cop_pkg.sv
// Shared types and helpers for the sparse-matrix coprocessor datapath.
// Frame width default and a wrap-around pointer increment for non power-of-two depths.
package sparse_cop_pkg;

    localparam int DATA_W_DEFAULT = 136;

    typedef logic [DATA_W_DEFAULT-1:0] frame_t;

    // Increment with explicit wrap so DEPTH need not be a power of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sparse_fall_edge.sv
// Falling-edge detector: one-cycle pulse on each 1->0 transition of d.
// History resets to 0, so a low input out of reset never produces a pulse.
module sparse_fall_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign pulse = q & ~d;

endmodule

// File: rtl/sparse_frame_buffer.sv
// DEPTH-entry circular frame FIFO between the UART comm block and the FPU/TX path.
// Writes come from rx_complete; reads fire on the falling edge of fpu_complete.
module sparse_frame_buffer
    import sparse_cop_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wen,
    input  logic [DATA_W-1:0] in_data,
    input  logic              fpu_complete,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count_next;
    logic              rd_req;
    logic              rd_accept;
    logic              wr_accept;

    sparse_fall_edge u_fall_edge (
        .clk   (clk),
        .reset (reset),
        .d     (fpu_complete),
        .pulse (rd_req)
    );

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // No fall-through: a read only sees frames already stored, while a write
    // into a full buffer is allowed when a read frees a slot on the same edge.
    assign rd_accept = rd_req & ~empty & ~clear;
    assign wr_accept = wen & (~full | rd_accept) & ~clear;

    assign wr_ptr_next = PTR_W'(next_ptr(32'(wr_ptr), DEPTH));
    assign rd_ptr_next = PTR_W'(next_ptr(32'(rd_ptr), DEPTH));

    always_comb begin
        count_next = count;
        if (wr_accept && !rd_accept) begin
            count_next = count + CNT_W'(1);
        end else if (rd_accept && !wr_accept) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            // out_data deliberately keeps the last frame read.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= rd_accept;
            count     <= count_next;
            if (wr_accept) begin
                wr_ptr <= wr_ptr_next;
            end
            if (rd_accept) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr_next;
            end
            if (wen && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (rd_req && !rd_accept) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
